// File: rtl/pulse_counter_pkg.sv
// Shared definitions for the multi-channel gated pulse counter: event modes
// and the saturating-increment helper used by every channel.
package pulse_counter_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_RISE  = 2'b01,
    MODE_FALL  = 2'b10,
    MODE_BOTH  = 2'b11
  } mode_e;

  // Returns {overflow_hit, increment}: an event at full scale is turned into
  // an overflow indication instead of wrapping the counter.
  function automatic logic [1:0] sat_step(input logic ev, input logic at_max);
    return {ev & at_max, ev & ~at_max};
  endfunction

endpackage

// File: rtl/pulse_counter_ch.sv
// One counter channel: input synchroniser, mode-selected event detector,
// saturating running count with sticky overflow, and window result register.
module pulse_counter_ch
  import pulse_counter_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             pulse_in,
  input  mode_e            mode_in,
  input  logic             en_in,
  input  logic             clear_in,
  input  logic             term_in,
  output logic [CNT_W-1:0] count_out,
  output logic             ovf_out
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       res_q, res_d;
  logic                   res_ovf_q, res_ovf_d;

  logic             s;
  logic             ev;
  logic [1:0]       step;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pulse_in};
    s      = sync_q[SYNC_STAGES-1];
    prev_d = s;

    ev = 1'b0;
    unique case (mode_in)
      MODE_LEVEL: ev = s;
      MODE_RISE:  ev = s & ~prev_q;
      MODE_FALL:  ev = ~s & prev_q;
      MODE_BOTH:  ev = s ^ prev_q;
    endcase

    step     = sat_step(ev, cnt_q == '1);
    cnt_next = cnt_q + CNT_W'(step[0]);
    ovf_next = ovf_q | step[1];

    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    res_ovf_d = res_ovf_q;

    // The terminal-cycle event is folded into the closing window's result.
    if (clear_in) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en_in) begin
      if (term_in) begin
        res_d     = cnt_next;
        res_ovf_d = ovf_next;
        cnt_d     = '0;
        ovf_d     = 1'b0;
      end else begin
        cnt_d = cnt_next;
        ovf_d = ovf_next;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  assign count_out = res_q;
  assign ovf_out   = res_ovf_q;

endmodule

// File: rtl/pulse_counter_mc.sv
// Multi-channel gated pulse counter: one shared gate timer drives CH_NUM
// channels so every window's results are latched coherently with one strobe.
module pulse_counter_mc
  import pulse_counter_pkg::*;
#(
  parameter int unsigned CH_NUM      = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned GATE_CYCLES = 200000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    en_in,
  input  logic                    clear_in,
  input  logic [1:0]              mode_in,
  input  logic [CH_NUM-1:0]       pulse_in,
  output logic [CH_NUM*CNT_W-1:0] count_out,
  output logic [CH_NUM-1:0]       ovf_out,
  output logic                    valid_out,
  output logic [31:0]             win_cnt_out
);

  localparam logic [31:0] LAST = 32'(GATE_CYCLES - 1);

  logic [31:0] timer_q, timer_d;
  logic        valid_q, valid_d;
  logic        term;
  mode_e       mode;

  assign mode = mode_e'(mode_in);
  assign term = (timer_q == LAST);

  always_comb begin
    timer_d = timer_q;
    valid_d = 1'b0;
    if (clear_in) begin
      timer_d = '0;
    end else if (en_in) begin
      timer_d = term ? '0 : timer_q + 32'd1;
      valid_d = term;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      timer_q <= '0;
      valid_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      valid_q <= valid_d;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    pulse_counter_ch #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .pulse_in (pulse_in[i]),
      .mode_in  (mode),
      .en_in    (en_in),
      .clear_in (clear_in),
      .term_in  (term),
      .count_out(count_out[i*CNT_W +: CNT_W]),
      .ovf_out  (ovf_out[i])
    );
  end

  assign valid_out   = valid_q;
  assign win_cnt_out = timer_q;

endmodule

// File: tb/tb_pulse_counter_mc.sv
// Directed bench for pulse_counter_mc: an 8-bit and a 4-bit instance share
// stimulus; windows of 100 cycles with hand-computed expected counts.
module tb_pulse_counter_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clear;
  logic [1:0]  mode;
  logic [1:0]  pulse;

  logic [15:0] count8;
  logic [1:0]  ovf8;
  logic        valid8;
  logic [31:0] win8;

  logic [7:0]  count4;
  logic [1:0]  ovf4;
  logic        valid4;
  logic [31:0] win4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pulse_counter_mc #(
    .CH_NUM(2), .CNT_W(8), .GATE_CYCLES(100), .SYNC_STAGES(2)
  ) dut (
    .clk_in(clk), .rst_in(rst), .en_in(en), .clear_in(clear), .mode_in(mode),
    .pulse_in(pulse), .count_out(count8), .ovf_out(ovf8), .valid_out(valid8),
    .win_cnt_out(win8)
  );

  pulse_counter_mc #(
    .CH_NUM(2), .CNT_W(4), .GATE_CYCLES(100), .SYNC_STAGES(2)
  ) dut4 (
    .clk_in(clk), .rst_in(rst), .en_in(en), .clear_in(clear), .mode_in(mode),
    .pulse_in(pulse), .count_out(count4), .ovf_out(ovf4), .valid_out(valid4),
    .win_cnt_out(win4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b1; clear = 1'b0; mode = 2'b01; pulse = 2'b00;
    tick(); tick(); tick();
    chk("rst_count", 32'(count8), 0);
    chk("rst_ovf", 32'(ovf8), 0);
    chk("rst_valid", 32'(valid8), 0);
    chk("rst_win", win8, 0);
    rst = 1'b0;

    // W1: rising mode, ch0 10 pulses spaced 5 cycles
    for (int c = 0; c < 100; c++) begin
      pulse = {1'b0, (c % 5 == 0 && c >= 5 && c <= 50)};
      if (c == 50) chk("w1_win50", win8, 50);
      if (c == 99) chk("w1_valid99", 32'(valid8), 0);
      tick();
    end
    chk("w1_valid", 32'(valid8), 1);
    chk("w1_ch0", 32'(count8[7:0]), 10);
    chk("w1_ch1", 32'(count8[15:8]), 0);
    chk("w1_ovf", 32'(ovf8), 0);
    chk("w1_win0", win8, 0);
    chk("w1_ch0_4b", 32'(count4[3:0]), 10);

    // W2: level mode, ch0 goes high at window start
    mode = 2'b00;
    for (int c = 0; c < 100; c++) begin
      pulse = 2'b01;
      if (c == 1) chk("w1_valid_1cyc", 32'(valid8), 0);
      tick();
    end
    chk("w2_ch0", 32'(count8[7:0]), 98);
    chk("w2_ovf", 32'(ovf8), 0);
    chk("w2_ch0_4b", 32'(count4[3:0]), 15);
    chk("w2_ovf_4b", 32'(ovf4), 1);

    // W3: level mode, ch0 high the whole window
    for (int c = 0; c < 100; c++) begin
      pulse = 2'b01;
      tick();
    end
    chk("w3_ch0", 32'(count8[7:0]), 100);
    chk("w3_valid", 32'(valid8), 1);

    // W4: both-edge mode, 6 transitions
    mode = 2'b11;
    for (int c = 0; c < 100; c++) begin
      pulse = {1'b0, ((c >= 10 && c < 20) || (c >= 30 && c < 40) || c >= 50)};
      tick();
    end
    chk("w4_ch0", 32'(count8[7:0]), 6);
    chk("w4_ch1", 32'(count8[15:8]), 0);

    // W5: rising mode, 20 edges on ch0 (saturates 4-bit), 7 on ch1
    mode = 2'b01;
    for (int c = 0; c < 100; c++) begin
      pulse = {(c % 10 == 3 && c <= 63), (c % 4 == 0 && c >= 4 && c <= 80)};
      tick();
    end
    chk("w5_ch0", 32'(count8[7:0]), 20);
    chk("w5_ch1", 32'(count8[15:8]), 7);
    chk("w5_ovf", 32'(ovf8), 0);
    chk("w5_valid_4b", 32'(valid4), 1);
    chk("w5_ch0_4b", 32'(count4[3:0]), 15);
    chk("w5_ch1_4b", 32'(count4[7:4]), 7);
    chk("w5_ovf_4b", 32'(ovf4), 1);

    // W6: 3 edges, saturation flag must clear
    for (int c = 0; c < 100; c++) begin
      pulse = {1'b0, (c == 10 || c == 20 || c == 30)};
      tick();
    end
    chk("w6_ch0_4b", 32'(count4[3:0]), 3);
    chk("w6_ovf_4b", 32'(ovf4), 0);
    chk("w6_ch0", 32'(count8[7:0]), 3);

    // W7: event landing on the terminal cycle belongs to this window
    for (int c = 0; c < 100; c++) begin
      pulse = {1'b0, (c == 10 || c == 97)};
      tick();
    end
    chk("w7_term_edge", 32'(count8[7:0]), 2);

    // W8: clear at cycle 50 restarts the window
    for (int c = 0; c < 151; c++) begin
      pulse = {1'b0, (c == 20 || c == 60 || c == 70 || c == 80)};
      clear = (c == 50);
      if (c == 100) chk("w8_no_strobe", 32'(valid8), 0);
      if (c == 120) chk("w8_hold_count", 32'(count8[7:0]), 2);
      if (c == 150) chk("w8_valid150", 32'(valid8), 0);
      tick();
    end
    clear = 1'b0;
    chk("w8_valid", 32'(valid8), 1);
    chk("w8_ch0", 32'(count8[7:0]), 3);

    // W9: clear on the terminal cycle suppresses the strobe
    for (int c = 0; c < 100; c++) begin
      pulse = {1'b0, (c == 30)};
      clear = (c == 99);
      tick();
    end
    clear = 1'b0;
    chk("w9_no_strobe", 32'(valid8), 0);
    chk("w9_hold_count", 32'(count8[7:0]), 3);
    chk("w9_win", win8, 0);

    // W10: en low cycles 30..69, strobe moves to cycle 140
    for (int c = 0; c < 140; c++) begin
      en = !(c >= 30 && c < 70);
      pulse = {(c >= 35 && c < 100), (c == 10 || c == 40 || c == 50 || c == 80)};
      if (c == 50) chk("w10_win_frozen", win8, 30);
      if (c == 100) chk("w10_no_strobe100", 32'(valid8), 0);
      tick();
    end
    en = 1'b1;
    chk("w10_valid", 32'(valid8), 1);
    chk("w10_ch0", 32'(count8[7:0]), 2);
    chk("w10_ch1", 32'(count8[15:8]), 0);

    // W11: reset at cycle 60 of a window
    for (int c = 0; c <= 60; c++) begin
      pulse = {(c >= 55), (c == 10)};
      rst = (c == 60);
      if (c == 59) chk("w11_pre_rst", 32'(count8[7:0]), 2);
      tick();
    end
    rst = 1'b0;
    chk("w11_rst_count", 32'(count8), 0);
    chk("w11_rst_valid", 32'(valid8), 0);
    chk("w11_rst_win", win8, 0);
    chk("w11_rst_ovf", 32'(ovf8), 0);

    // W12: input high across reset release yields one rising event
    for (int c = 0; c < 100; c++) begin
      pulse = {1'b1, (c == 10 || c == 20)};
      if (c == 99) chk("w12_valid99", 32'(valid8), 0);
      tick();
    end
    chk("w12_valid", 32'(valid8), 1);
    chk("w12_ch0", 32'(count8[7:0]), 2);
    chk("w12_ch1", 32'(count8[15:8]), 1);
    chk("w12_win4", win4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_counter_mc.md
Name: pulse_counter_mc

Overview:
Multi-channel gated pulse/frequency counter, parametrised successor to the single-channel LED-board pulse counter. Each channel synchronises an asynchronous pulse input, detects events per a selectable mode, and counts them over a common gate window. At window end all counts are latched simultaneously and announced with a one-cycle strobe. Sits between board pulse inputs and display/readout logic (segment drivers, UART reporter).

Parameters:
CH_NUM, 2, number of independent pulse channels (1..16)
CNT_W, 16, per-channel counter and result width in bits
GATE_CYCLES, 200000000, gate window length in clk_in cycles (>=2)
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous reset, active-high
en_in  input  1  1 = gate timer and counters run; 0 = freeze all state
clear_in  input  1  synchronous window restart, no result update
mode_in  input  2  event mode: 00 level-high, 01 rising, 10 falling, 11 both edges
pulse_in  input  CH_NUM  asynchronous pulse inputs, bit i = channel i
count_out  output  CH_NUM*CNT_W  latched results, channel i at [i*CNT_W +: CNT_W]
ovf_out  output  CH_NUM  latched per-channel saturation flag for last window
valid_out  output  1  one-cycle strobe: count_out/ovf_out updated this cycle
win_cnt_out  output  32  current gate timer value (debug/readout)

Behaviour:
- Clock clk_in; reset rst_in is synchronous and active-high. On reset: count_out=0, ovf_out=0, valid_out=0, win_cnt_out=0, all synchroniser, edge-history and running counters=0.
- Synchroniser: SYNC_STAGES flops per channel; event detect uses synced value s and its 1-cycle-delayed copy p. Latency pin-to-count = SYNC_STAGES+1 cycles.
- Events: level-high: s=1 each cycle; rising: s&~p; falling: ~s&p; both: s^p. Input high at reset release produces one rising event (p resets to 0) — required, not a bug.
- Gate timer: counts 0..GATE_CYCLES-1 while en_in=1; on cycle with timer==GATE_CYCLES-1 (terminal): timer->0, each channel's result = running count + event-this-cycle (saturating), ovf_out latched, running counts and sticky ovf cleared, valid_out=1 next cycle together with new count_out.
- valid_out high exactly one cycle per completed window; first strobe GATE_CYCLES cycles after reset release with en_in=1.
- Saturation: running count stops at 2^CNT_W-1; further events set channel sticky ovf. Result latched as all-ones with ovf=1.
- en_in=0: timer, running counts, sticky ovf hold; synchroniser and p keep tracking (no spurious edge on re-enable); events during disable are discarded; no strobe.
- clear_in=1 (priority below rst_in, above en_in): timer, running counts, sticky ovf -> 0; count_out/ovf_out unchanged; valid_out=0. If clear_in coincides with terminal cycle, clear wins, no strobe.
- mode_in change takes effect next cycle; window not restarted; partial window mixes modes (software clears if needed).
- win_cnt_out = current timer value, 32-bit zero-extended.
- All channels share one gate timer; results are coherent (same window).

Decomposition:
- Package pulse_counter_pkg: mode encodings MODE_LEVEL/MODE_RISE/MODE_FALL/MODE_BOTH (2-bit), saturation helper function.
- Sub-module pulse_counter_ch: one channel (synchroniser, edge detect, saturating counter, sticky ovf, result register), instantiated CH_NUM times by generate; top holds gate timer, clear/en priority and valid_out.

Test Plan:
- CH_NUM=2, CNT_W=8, GATE_CYCLES=100, mode=01; ch0 10 one-cycle pulses spaced 5 cycles, ch1 idle -> strobe at cycle 100, count ch0=10, ch1=0, ovf=00.
- mode=00, ch0 held high whole window -> ch0=100 (first window = 100-SYNC_STAGES), ovf=0; mode=11 with 6 toggles -> 6.
- CNT_W=4, 20 rising edges in window -> ch0=15, ovf_out[0]=1; next window 3 edges -> 3, ovf=0.
- Edge on terminal cycle -> counted in closing window, not next; clear_in pulsed at cycle 50 -> no strobe at 100, next strobe at 150, count_out unchanged meanwhile.
- en_in low cycles 30-69 with pulses present -> strobe delayed to cycle 140, pulses during disable not counted.
- rst_in asserted mid-window (cycle 60) -> all outputs 0 next cycle, next strobe 100 cycles after release.
